// File: rtl/bus_arb_pkg.sv
// -----------------------------------------------------------------------------
// bus_arb_pkg
// Shared definitions for the round-robin bus arbiter slice:
//   SEL_W           - width of the binary bus-select index (32-to-1 mux)
//   DEFAULT_NUM_REQ - default number of bus requesters
//   arb_state_t     - arbiter FSM states (IDLE: no owner, OWN: one owner)
// -----------------------------------------------------------------------------
package bus_arb_pkg;

    localparam int SEL_W           = 5;
    localparam int DEFAULT_NUM_REQ = 24;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// bus_arbiter_if
// Request/grant bundle between the requesters and the arbiter.
//   req       - per-requester request, bit i is requester i
//   grant     - one-hot grant, zero when the bus is idle
//   bus_sel   - binary index of the granted requester
//   bus_valid - high exactly when grant is non-zero
//   timeout   - one-cycle pulse when a grant is revoked by tenure expiry
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface bus_arbiter_if
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ
);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic [SEL_W-1:0]   bus_sel;
    logic               bus_valid;
    logic               timeout;

    modport master (
        output req,
        input  grant,
        input  bus_sel,
        input  bus_valid,
        input  timeout
    );

    modport slave (
        input  req,
        output grant,
        output bus_sel,
        output bus_valid,
        output timeout
    );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin scan: finds the first requester that is asserted
// and not masked, starting at the pointer and scanning upward with wrap from
// NUM_REQ-1 back to 0.
//   i_req   - request vector
//   i_mask  - requesters excluded from this scan
//   i_ptr   - scan start index (must be below NUM_REQ)
//   o_found - an eligible requester exists
//   o_index - index of the chosen requester (0 when none found)
// -----------------------------------------------------------------------------
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [NUM_REQ-1:0] i_mask,
    input  logic [SEL_W-1:0]   i_ptr,
    output logic               o_found,
    output logic [SEL_W-1:0]   o_index
);

    logic [NUM_REQ-1:0] w_eligible;

    assign w_eligible = i_req & ~i_mask;

    // Walk offsets 0..NUM_REQ-1 from the pointer; the first hit wins, so the
    // requester sitting just below the pointer ends up lowest priority.
    always_comb begin : pickScan
        int cand;
        o_found = 1'b0;
        o_index = '0;
        cand    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(i_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!o_found && w_eligible[cand]) begin
                o_found = 1'b1;
                o_index = SEL_W'(cand);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Round-robin, non-preemptive bus arbiter with registered outputs. An owner
// keeps the bus while its request stays high; on release the next requester
// (scanning from owner+1) is granted on the very next cycle.
// Optional feature macro: BUS_ARB_TIMEOUT_EN - bounds each grant to
// TIMEOUT_CYCLES cycles, pulses timeout on revocation and masks the revoked
// requester until it drops its request.
// Ports:
//   clk - clock, rising edge
//   clr - synchronous active-low reset
//   bus - bus_arbiter_if.slave (req in; grant, bus_sel, bus_valid, timeout out)
// -----------------------------------------------------------------------------
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEFAULT_NUM_REQ,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic           clk,
    input  logic           clr,
    bus_arbiter_if.slave   bus
);

    localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    arb_state_t         r_state;
    logic [SEL_W-1:0]   r_owner;
    logic [SEL_W-1:0]   r_ptr;
    logic [NUM_REQ-1:0] r_grant;
    logic [SEL_W-1:0]   r_busSel;
    logic               r_busValid;

    logic               w_ownerReq;
    logic [NUM_REQ-1:0] w_ownerOneHot;
    logic [SEL_W-1:0]   w_nextPtr;
    logic [SEL_W-1:0]   w_scanPtr;
    logic [NUM_REQ-1:0] w_maskEff;
    logic               w_expire;
    logic               w_release;
    logic               w_found;
    logic [SEL_W-1:0]   w_pickIdx;
    logic [NUM_REQ-1:0] w_pickOneHot;

    assign w_ownerReq    = bus.req[r_owner];
    assign w_ownerOneHot = ONE_HOT_0 << r_owner;
    assign w_nextPtr     = (r_owner == SEL_W'(NUM_REQ - 1)) ? '0 : r_owner + SEL_W'(1);

    // While owning, the only scan that matters is the one for the successor,
    // which starts just past the owner; in IDLE the stored pointer is used.
    assign w_scanPtr     = (r_state == OWN) ? w_nextPtr : r_ptr;

    assign w_release     = (r_state == OWN) && (!w_ownerReq || w_expire);
    assign w_pickOneHot  = ONE_HOT_0 << w_pickIdx;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rrPick (
        .i_req   (bus.req),
        .i_mask  (w_maskEff),
        .i_ptr   (w_scanPtr),
        .o_found (w_found),
        .o_index (w_pickIdx)
    );

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int TEN_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TEN_W-1:0]   r_tenure;
    logic [NUM_REQ-1:0] r_mask;
    logic               r_timeout;
    logic               w_grantNew;

    // Expiry only counts when the owner still wants the bus; a plain release
    // in the same cycle is an ordinary release with no pulse.
    assign w_expire   = (r_state == OWN) && w_ownerReq &&
                        (r_tenure == TEN_W'(TIMEOUT_CYCLES));

    // The expiring owner is excluded from the successor scan immediately,
    // not just from the following cycle on.
    assign w_maskEff  = r_mask | (w_expire ? w_ownerOneHot : '0);

    assign w_grantNew = w_found && ((r_state == IDLE) || w_release);

    // Tenure starts at 1 on the grant edge so that the owner holds the bus for
    // exactly TIMEOUT_CYCLES visible cycles. Mask bits clear once the masked
    // requester is sampled with its request low.
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_tenure  <= '0;
            r_mask    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            r_mask    <= w_maskEff & bus.req;
            if (w_grantNew) begin
                r_tenure <= TEN_W'(1);
            end else if ((r_state == OWN) && !w_release) begin
                r_tenure <= r_tenure + TEN_W'(1);
            end else begin
                r_tenure <= '0;
            end
        end
    end

    assign bus.timeout = r_timeout;
`else
    assign w_expire    = 1'b0;
    assign w_maskEff   = '0;
    assign bus.timeout = 1'b0;
`endif

    // Arbiter FSM with registered grant/select/valid. A release hands the bus
    // straight to the successor when one exists, otherwise drops to IDLE with
    // all outputs cleared so bus_sel reads 0 whenever bus_valid is low.
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_ptr      <= '0;
            r_grant    <= '0;
            r_busSel   <= '0;
            r_busValid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state    <= OWN;
                        r_owner    <= w_pickIdx;
                        r_grant    <= w_pickOneHot;
                        r_busSel   <= w_pickIdx;
                        r_busValid <= 1'b1;
                    end
                end
                OWN: begin
                    if (w_release) begin
                        r_ptr <= w_nextPtr;
                        if (w_found) begin
                            r_owner    <= w_pickIdx;
                            r_grant    <= w_pickOneHot;
                            r_busSel   <= w_pickIdx;
                            r_busValid <= 1'b1;
                        end else begin
                            r_state    <= IDLE;
                            r_owner    <= '0;
                            r_grant    <= '0;
                            r_busSel   <= '0;
                            r_busValid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant     = r_grant;
    assign bus.bus_sel   = r_busSel;
    assign bus.bus_valid = r_busValid;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Directed bench for bus_arbiter (NUM_REQ = 24, TIMEOUT_CYCLES = 4). The
// tenure-expiry scenario is only built when BUS_ARB_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int NREQ = 24;

    logic clk;
    logic clr;

    int compareCount  = 0;
    int mismatchCount = 0;

    bus_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    bus_arbiter #(
        .NUM_REQ        (NREQ),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive clr/req, let one rising edge sample them, then settle 1 ns past
    // the edge so outputs are read away from the active edge.
    task automatic applyStimulus(input logic clrValue, input logic [NREQ-1:0] reqValue);
        clr     = clrValue;
        bus.req = reqValue;
        @(posedge clk);
        #1;
    endtask

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Checks grant, bus_sel and bus_valid against an owner index (or idle).
    task automatic checkBus(input string tag, input bit busy, input int owner);
        logic [NREQ-1:0] expGrant;
        expGrant = '0;
        if (busy) expGrant[owner] = 1'b1;
        checkOutput({tag, ".grant"}, 32'(bus.grant), 32'(expGrant));
        checkOutput({tag, ".sel"},   32'(bus.bus_sel), busy ? 32'(owner) : 32'd0);
        checkOutput({tag, ".valid"}, 32'(bus.bus_valid), busy ? 32'd1 : 32'd0);
    endtask

    function automatic logic [NREQ-1:0] bitsOf(input int a, input int b);
        logic [NREQ-1:0] v;
        v = '0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        return v;
    endfunction

    initial begin
        clr     = 1'b0;
        bus.req = '0;

        // Reset state
        applyStimulus(1'b0, '0);
        applyStimulus(1'b0, '0);
        checkBus("reset", 1'b0, 0);
        checkOutput("reset.timeout", 32'(bus.timeout), 32'd0);

        // Single requester 21, one-cycle latency, then release to IDLE (ptr 22)
        applyStimulus(1'b1, 24'h200000);
        checkBus("req21", 1'b1, 21);
        checkOutput("req21.selbits", 32'(bus.bus_sel), 32'b10101);
        applyStimulus(1'b1, '0);
        checkBus("rel21", 1'b0, 0);

        // Fresh reset so the pointer is 0; bits 3 and 7 -> 3, hold, then 7, then idle
        applyStimulus(1'b0, '0);
        applyStimulus(1'b1, bitsOf(3, 7));
        checkBus("rr3", 1'b1, 3);
        applyStimulus(1'b1, bitsOf(3, 7));
        checkBus("hold3", 1'b1, 3);
        applyStimulus(1'b1, bitsOf(7, -1));
        checkBus("b2b7", 1'b1, 7);
        applyStimulus(1'b1, '0);
        checkBus("idle7", 1'b0, 0);

        // Pointer 8: owner 23 releases while bit 0 requests -> wrap to 0
        applyStimulus(1'b1, bitsOf(23, -1));
        checkBus("own23", 1'b1, 23);
        applyStimulus(1'b1, bitsOf(0, -1));
        checkBus("wrap0", 1'b1, 0);
        applyStimulus(1'b1, '0);
        checkBus("idle0", 1'b0, 0);

        // Pointer 1: owner 5 drops for one cycle and re-raises while 9 waits
        applyStimulus(1'b1, bitsOf(5, -1));
        checkBus("own5", 1'b1, 5);
        applyStimulus(1'b1, bitsOf(5, 9));
        checkBus("nopre5", 1'b1, 5);
        applyStimulus(1'b1, bitsOf(9, -1));
        checkBus("move9", 1'b1, 9);
        applyStimulus(1'b1, bitsOf(5, 9));
        checkBus("keep9", 1'b1, 9);
        applyStimulus(1'b1, '0);
        checkBus("idle9", 1'b0, 0);

        // Pointer 10: owner 12 reset mid-tenure, regranted one cycle after release
        applyStimulus(1'b1, bitsOf(12, -1));
        checkBus("own12", 1'b1, 12);
        applyStimulus(1'b0, bitsOf(12, -1));
        checkBus("clr12", 1'b0, 0);
        applyStimulus(1'b1, bitsOf(12, -1));
        checkBus("regrant12", 1'b1, 12);

        // Pointer 13 after release of 12: bits 2 and 20 -> 20 first, then 2
        applyStimulus(1'b1, '0);
        checkBus("idle12", 1'b0, 0);
        applyStimulus(1'b1, bitsOf(2, 20));
        checkBus("scan20", 1'b1, 20);
        applyStimulus(1'b1, bitsOf(2, -1));
        checkBus("next2", 1'b1, 2);
        applyStimulus(1'b1, '0);
        checkBus("idle2", 1'b0, 0);

`ifdef BUS_ARB_TIMEOUT_EN
        // Tenure limit 4: owner 2 held for 4 cycles, then revoked in favour of 4
        applyStimulus(1'b0, '0);
        for (int c = 1; c <= 4; c++) begin
            applyStimulus(1'b1, bitsOf(2, 4));
            checkBus($sformatf("tenure2_%0d", c), 1'b1, 2);
            checkOutput($sformatf("tenure2_%0d.timeout", c), 32'(bus.timeout), 32'd0);
        end
        applyStimulus(1'b1, bitsOf(2, 4));
        checkBus("expire2", 1'b1, 4);
        checkOutput("expire2.timeout", 32'(bus.timeout), 32'd1);
        applyStimulus(1'b1, bitsOf(2, 4));
        checkBus("own4", 1'b1, 4);
        checkOutput("own4.timeout", 32'(bus.timeout), 32'd0);
        // 4 releases; 2 is still masked because its request never dropped
        applyStimulus(1'b1, bitsOf(2, -1));
        checkBus("masked2", 1'b1 == 1'b0, 0);
        applyStimulus(1'b1, '0);
        checkBus("unmask2", 1'b0, 0);
        applyStimulus(1'b1, bitsOf(2, -1));
        checkBus("regrant2", 1'b1, 2);
        applyStimulus(1'b1, '0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 24, SHALL set the number of bus requesters; legal range is 2..32.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, SHALL set the maximum grant tenure in cycles; used only when BUS_ARB_TIMEOUT_EN is defined.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 clr  input  1  SHALL be the reset; synchronous, active-low.
REQ-005 req  input  NUM_REQ  SHALL carry per-requester bus requests; bit i is requester i.
REQ-006 grant  output  NUM_REQ  SHALL be the one-hot grant, all-zero when the bus is idle.
REQ-007 bus_sel  output  5  SHALL be the binary index of the granted requester, driving the 32-to-1 bus multiplexer select.
REQ-008 bus_valid  output  1  SHALL be high exactly when grant is non-zero.
REQ-009 timeout  output  1  SHALL pulse for one cycle when a grant is revoked by timeout; tied 0 without BUS_ARB_TIMEOUT_EN.

Function
REQ-010 The block SHALL be a two-state FSM: IDLE (no owner) and OWN (one owner held in a registered index).
REQ-011 In IDLE with req != 0, the next cycle SHALL enter OWN, granting the first asserted requester at or after the round-robin pointer, scanning upward with wrap from NUM_REQ-1 to 0.
REQ-012 Grant latency SHALL be exactly one cycle from req sampled high to grant/bus_valid high.
REQ-013 In OWN, the grant SHALL persist while req[owner] stays high; other requests SHALL not preempt.
REQ-014 When req[owner] is sampled low, the pointer SHALL become (owner+1) mod NUM_REQ and the grant SHALL drop the following cycle.
REQ-015 On release with other requests pending, the next owner SHALL be granted in the cycle immediately after release (back-to-back, no idle cycle), selected from the updated pointer.
REQ-016 On release with no other requests pending, the FSM SHALL return to IDLE and grant, bus_sel and bus_valid SHALL be 0.
REQ-017 Simultaneous owner release and owner re-request in the same cycle SHALL be treated as release; the old owner is lowest priority in the next scan.
REQ-018 grant, bus_sel and bus_valid SHALL be registered outputs; bus_sel SHALL equal 0 whenever bus_valid is low.
REQ-019 bus_sel SHALL never exceed NUM_REQ-1.

Reset
REQ-020 With clr low at a clock edge: FSM to IDLE, pointer 0, grant 0, bus_sel 0, bus_valid 0, timeout 0, tenure counter 0.
REQ-021 Reset asserted mid-tenure SHALL revoke the grant on that edge; first grant after reset release follows REQ-011/REQ-012.

Configuration
REQ-022 With BUS_ARB_TIMEOUT_EN defined, a tenure counter SHALL count cycles in OWN; when it reaches TIMEOUT_CYCLES the grant SHALL be revoked next cycle, timeout pulse once, pointer advance to owner+1, and that requester SHALL be masked from arbitration until its req is sampled low.
REQ-023 Without BUS_ARB_TIMEOUT_EN, no counter or mask SHALL exist; tenure is unbounded and timeout is constant 0.

Structure
REQ-024 Shared package bus_arb_pkg SHALL hold SEL_W=5, the default NUM_REQ, and the FSM state enum (IDLE, OWN).
REQ-025 The round-robin scan SHALL be a combinational sub-module rr_pick (inputs req, mask, pointer; outputs found and index).

Verification
REQ-026 Reset, then req=24'h200000 (bit 21) -> one cycle later grant bit 21, bus_sel=5'b10101, bus_valid=1.
REQ-027 req bits 3 and 7 together from pointer 0 -> grant 3; drop bit 3 -> next cycle grant 7 with no idle cycle; drop 7 -> IDLE, bus_sel=0.
REQ-028 Owner 23 releases while bit 0 requests -> next grant 0 (wrap-around), pointer=0.
REQ-029 Owner 5 drops and re-raises req in the same cycle while bit 9 requests -> grant moves to 9.
REQ-030 clr low during tenure of owner 12 -> grant 0 on that edge; after clr high with req bit 12 still set -> grant 12 one cycle later.
REQ-031 With BUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, req bits 2 and 4 held -> grant 2 for 4 cycles, timeout pulse, grant 4; bit 2 not regranted until it drops req.
